mul_div_issue_queue: RTL and testbench

- In-order issue queue feeding mul_div_unit.
- Accepts dispatched mul/div instruction pairs:
  - slot 1 carries the HI/LO operands and HI dest.
  - slot 2 carries rs/rt and the LO/GPR dest.
- Captures operand values from wakeup/bypass buses and issues the oldest pair once all four operands are ready.
- Uses the issue_to_mul_div_valid / mul_div_allowin handshake.

---
 rtl/mul_div_issue_queue.sv | 192 +++++++++++++++++++
 tb/tb_mul_div_issue_queue.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_issue_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mul_div_issue_queue
// Purpose  : In-order issue queue for mul/div instruction pairs. It captures
//            operands from the wakeup buses and issues the head pair once all
//            four operands are ready.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PHY_W = 6,
    parameter int ROB_W = 4,
    parameter int OP_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    output logic                 dispatch_allowin,
    input  logic [OP_W-1:0]      dispatch_op,
    input  logic                 dispatch_rf_we1,
    input  logic                 dispatch_rf_we2,
    input  logic [PHY_W-1:0]     dispatch_phy_dest1,
    input  logic [PHY_W-1:0]     dispatch_phy_dest2,
    input  logic [ROB_W-1:0]     dispatch_rob1,
    input  logic [ROB_W-1:0]     dispatch_rob2,
    input  logic [4*PHY_W-1:0]   dispatch_src_tag,
    input  logic [3:0]           dispatch_src_rdy,
    input  logic [4*32-1:0]      dispatch_src_val,
    input  logic [1:0]           wake_we,
    input  logic [2*PHY_W-1:0]   wake_dest,
    input  logic [2*32-1:0]      wake_value,
    output logic                 issue_valid,
    input  logic                 mul_div_allowin,
    output logic [OP_W-1:0]      issue_op,
    output logic                 issue_rf_we1,
    output logic                 issue_rf_we2,
    output logic [PHY_W-1:0]     issue_phy_dest1,
    output logic [PHY_W-1:0]     issue_phy_dest2,
    output logic [ROB_W-1:0]     issue_rob1,
    output logic [ROB_W-1:0]     issue_rob2,
    output logic [31:0]          issue_hi,
    output logic [31:0]          issue_lo,
    output logic [31:0]          issue_src1,
    output logic [31:0]          issue_src2
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]             head;
    logic [AW:0]             tail;
    logic [AW-1:0]           head_idx;
    logic [AW-1:0]           tail_idx;
    logic                    full;
    logic                    push;
    logic                    pop;

    logic [DEPTH-1:0]        ent_valid;
    logic [OP_W-1:0]         ent_op    [DEPTH];
    logic [DEPTH-1:0]        ent_we1;
    logic [DEPTH-1:0]        ent_we2;
    logic [PHY_W-1:0]        ent_dest1 [DEPTH];
    logic [PHY_W-1:0]        ent_dest2 [DEPTH];
    logic [ROB_W-1:0]        ent_rob1  [DEPTH];
    logic [ROB_W-1:0]        ent_rob2  [DEPTH];
    logic [3:0][PHY_W-1:0]   ent_tag   [DEPTH];
    logic [3:0]              ent_rdy   [DEPTH];
    logic [3:0][31:0]        ent_val   [DEPTH];

    logic [3:0]              push_rdy;
    logic [3:0][31:0]        push_val;

    assign head_idx         = head[AW-1:0];
    assign tail_idx         = tail[AW-1:0];
    assign full             = (head_idx == tail_idx) && (head[AW] != tail[AW]);
    assign dispatch_allowin = !full;
    assign push             = dispatch_valid && !full;
    assign issue_valid      = ent_valid[head_idx] && (&ent_rdy[head_idx]);
    assign pop              = issue_valid && mul_div_allowin;

    // Same-cycle wakeup forwarding into the entry being written; port 0 is
    // evaluated last so it takes priority on a double match.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            push_rdy[k] = dispatch_src_rdy[k];
            push_val[k] = dispatch_src_val[k*32 +: 32];
            if (wake_we[1] && (wake_dest[PHY_W +: PHY_W] == dispatch_src_tag[k*PHY_W +: PHY_W])) begin
                push_rdy[k] = 1'b1;
                push_val[k] = wake_value[63:32];
            end
            if (wake_we[0] && (wake_dest[0 +: PHY_W] == dispatch_src_tag[k*PHY_W +: PHY_W])) begin
                push_rdy[k] = 1'b1;
                push_val[k] = wake_value[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_we1   <= '0;
            ent_we2   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent_op[e]    <= '0;
                ent_dest1[e] <= '0;
                ent_dest2[e] <= '0;
                ent_rob1[e]  <= '0;
                ent_rob2[e]  <= '0;
                ent_tag[e]   <= '0;
                ent_rdy[e]   <= '0;
                ent_val[e]   <= '0;
            end
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent_rdy[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                for (int k = 0; k < 4; k++) begin
                    if (ent_valid[e] && !ent_rdy[e][k]) begin
                        if (wake_we[0] && (wake_dest[0 +: PHY_W] == ent_tag[e][k])) begin
                            ent_rdy[e][k] <= 1'b1;
                            ent_val[e][k] <= wake_value[31:0];
                        end else if (wake_we[1] && (wake_dest[PHY_W +: PHY_W] == ent_tag[e][k])) begin
                            ent_rdy[e][k] <= 1'b1;
                            ent_val[e][k] <= wake_value[63:32];
                        end
                    end
                end
            end

            if (pop) begin
                ent_valid[head_idx] <= 1'b0;
                ent_rdy[head_idx]   <= '0;
                head                <= head + PTR_ONE;
            end

            // Push never targets the head slot of a non-empty queue, so it
            // cannot collide with the pop above.
            if (push) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_op[tail_idx]    <= dispatch_op;
                ent_we1[tail_idx]   <= dispatch_rf_we1;
                ent_we2[tail_idx]   <= dispatch_rf_we2;
                ent_dest1[tail_idx] <= dispatch_phy_dest1;
                ent_dest2[tail_idx] <= dispatch_phy_dest2;
                ent_rob1[tail_idx]  <= dispatch_rob1;
                ent_rob2[tail_idx]  <= dispatch_rob2;
                ent_tag[tail_idx]   <= dispatch_src_tag;
                ent_rdy[tail_idx]   <= push_rdy;
                ent_val[tail_idx]   <= push_val;
                tail                <= tail + PTR_ONE;
            end
        end
    end

    always_comb begin
        issue_op        = '0;
        issue_rf_we1    = 1'b0;
        issue_rf_we2    = 1'b0;
        issue_phy_dest1 = '0;
        issue_phy_dest2 = '0;
        issue_rob1      = '0;
        issue_rob2      = '0;
        issue_hi        = '0;
        issue_lo        = '0;
        issue_src1      = '0;
        issue_src2      = '0;
        if (ent_valid[head_idx]) begin
            issue_op        = ent_op[head_idx];
            issue_rf_we1    = ent_we1[head_idx];
            issue_rf_we2    = ent_we2[head_idx];
            issue_phy_dest1 = ent_dest1[head_idx];
            issue_phy_dest2 = ent_dest2[head_idx];
            issue_rob1      = ent_rob1[head_idx];
            issue_rob2      = ent_rob2[head_idx];
            issue_hi        = ent_val[head_idx][0];
            issue_lo        = ent_val[head_idx][1];
            issue_src1      = ent_val[head_idx][2];
            issue_src2      = ent_val[head_idx][3];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_issue_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_div_issue_queue
// Purpose  : Directed, table-driven self-checking bench for the issue queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_issue_queue;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         dispatch_valid;
    logic         dispatch_allowin;
    logic [4:0]   dispatch_op;
    logic         dispatch_rf_we1;
    logic         dispatch_rf_we2;
    logic [5:0]   dispatch_phy_dest1;
    logic [5:0]   dispatch_phy_dest2;
    logic [3:0]   dispatch_rob1;
    logic [3:0]   dispatch_rob2;
    logic [23:0]  dispatch_src_tag;
    logic [3:0]   dispatch_src_rdy;
    logic [127:0] dispatch_src_val;
    logic [1:0]   wake_we;
    logic [11:0]  wake_dest;
    logic [63:0]  wake_value;
    logic         issue_valid;
    logic         mul_div_allowin;
    logic [4:0]   issue_op;
    logic         issue_rf_we1;
    logic         issue_rf_we2;
    logic [5:0]   issue_phy_dest1;
    logic [5:0]   issue_phy_dest2;
    logic [3:0]   issue_rob1;
    logic [3:0]   issue_rob2;
    logic [31:0]  issue_hi;
    logic [31:0]  issue_lo;
    logic [31:0]  issue_src1;
    logic [31:0]  issue_src2;

    int checks;
    int failures;

    mul_div_issue_queue #(
        .DEPTH (4),
        .PHY_W (6),
        .ROB_W (4),
        .OP_W  (5)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_allowin   (dispatch_allowin),
        .dispatch_op        (dispatch_op),
        .dispatch_rf_we1    (dispatch_rf_we1),
        .dispatch_rf_we2    (dispatch_rf_we2),
        .dispatch_phy_dest1 (dispatch_phy_dest1),
        .dispatch_phy_dest2 (dispatch_phy_dest2),
        .dispatch_rob1      (dispatch_rob1),
        .dispatch_rob2      (dispatch_rob2),
        .dispatch_src_tag   (dispatch_src_tag),
        .dispatch_src_rdy   (dispatch_src_rdy),
        .dispatch_src_val   (dispatch_src_val),
        .wake_we            (wake_we),
        .wake_dest          (wake_dest),
        .wake_value         (wake_value),
        .issue_valid        (issue_valid),
        .mul_div_allowin    (mul_div_allowin),
        .issue_op           (issue_op),
        .issue_rf_we1       (issue_rf_we1),
        .issue_rf_we2       (issue_rf_we2),
        .issue_phy_dest1    (issue_phy_dest1),
        .issue_phy_dest2    (issue_phy_dest2),
        .issue_rob1         (issue_rob1),
        .issue_rob2         (issue_rob2),
        .issue_hi           (issue_hi),
        .issue_lo           (issue_lo),
        .issue_src1         (issue_src1),
        .issue_src2         (issue_src2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand packing used throughout: {src2, src1, lo, hi}.
    typedef struct {
        logic [4:0]   op;
        logic [3:0]   rob1;
        logic [3:0]   rdy;
        logic [23:0]  tags;
        logic [127:0] vals;
        logic [1:0]   wwe;
        logic [11:0]  wdest;
        logic [63:0]  wval;
        logic         exp_valid;
        logic [127:0] exp_vals;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [4:0] op, input logic [3:0] rob1, input logic [3:0] rdy,
                              input logic [23:0] tags, input logic [127:0] vals);
        dispatch_op        = op;
        dispatch_rob1      = rob1;
        dispatch_rob2      = ~rob1;
        dispatch_phy_dest1 = 6'd40 + {2'b00, rob1};
        dispatch_phy_dest2 = 6'd50 + {2'b00, rob1};
        dispatch_rf_we1    = 1'b1;
        dispatch_rf_we2    = rob1[0];
        dispatch_src_tag   = tags;
        dispatch_src_rdy   = rdy;
        dispatch_src_val   = vals;
    endtask

    task automatic clear_wake();
        wake_we    = 2'b00;
        wake_dest  = '0;
        wake_value = '0;
    endtask

    initial begin
        logic [5:0] exp_d1;
        logic [5:0] exp_d2;
        checks   = 0;
        failures = 0;

        vecs[0] = '{5'd1, 4'd1, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},
                    {32'hFFFF_FFFD, 32'd7, 32'h22, 32'h11}, 2'b00, 12'd0, 64'd0,
                    1'b1, {32'hFFFF_FFFD, 32'd7, 32'h22, 32'h11}};
        vecs[1] = '{5'd3, 4'd2, 4'b1011, {6'd21, 6'd20, 6'd19, 6'd18},
                    {32'h33, 32'hDEAD, 32'h66, 32'h55}, 2'b10, {6'd20, 6'd0}, {32'hABCD, 32'h0},
                    1'b1, {32'h33, 32'hABCD, 32'h66, 32'h55}};
        vecs[2] = '{5'd5, 4'd3, 4'b1110, {6'd31, 6'd30, 6'd29, 6'd3},
                    {32'h4, 32'h3, 32'h2, 32'hBAD}, 2'b11, {6'd3, 6'd3}, {32'd2, 32'd1},
                    1'b1, {32'h4, 32'h3, 32'h2, 32'h1}};
        vecs[3] = '{5'd6, 4'd4, 4'b0111, {6'd12, 6'd11, 6'd10, 6'd9},
                    {32'h0, 32'h8, 32'h7, 32'h6}, 2'b01, {6'd0, 6'd13}, {32'h0, 32'h77},
                    1'b0, 128'd0};
        vecs[4] = '{5'd2, 4'd5, 4'b1101, {6'd17, 6'd16, 6'd9, 6'd15},
                    {32'h1, 32'h2, 32'h0, 32'h3}, 2'b11, {6'd9, 6'd8}, {32'h99, 32'h88},
                    1'b1, {32'h1, 32'h2, 32'h99, 32'h3}};

        reset           = 1'b0;
        flush           = 1'b0;
        dispatch_valid  = 1'b0;
        mul_div_allowin = 1'b0;
        drive_pair(5'd0, 4'd0, 4'd0, 24'd0, 128'd0);
        clear_wake();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("reset_allowin", {31'd0, dispatch_allowin}, 32'd1);
        chk("reset_issue_src1", issue_src1, 32'd0);
        reset = 1'b1;
        tick();

        // MULT with everything ready issues one cycle after dispatch.
        drive_pair(5'd1, 4'd0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},
                   {32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0});
        mul_div_allowin = 1'b1;
        dispatch_valid  = 1'b1;
        chk("mult_not_same_cycle", {31'd0, issue_valid}, 32'd0);
        tick();
        dispatch_valid = 1'b0;
        chk("mult_issue_valid", {31'd0, issue_valid}, 32'd1);
        chk("mult_src1", issue_src1, 32'd7);
        chk("mult_src2", issue_src2, 32'hFFFF_FFFD);
        tick();
        chk("mult_empty_after", {31'd0, issue_valid}, 32'd0);
        mul_div_allowin = 1'b0;

        for (int i = 0; i < 5; i++) begin
            drive_pair(vecs[i].op, vecs[i].rob1, vecs[i].rdy, vecs[i].tags, vecs[i].vals);
            wake_we        = vecs[i].wwe;
            wake_dest      = vecs[i].wdest;
            wake_value     = vecs[i].wval;
            dispatch_valid = 1'b1;
            tick();
            dispatch_valid = 1'b0;
            clear_wake();
            exp_d1 = 6'd40 + {2'b00, vecs[i].rob1};
            exp_d2 = 6'd50 + {2'b00, vecs[i].rob1};
            chk($sformatf("vec%0d_valid", i), {31'd0, issue_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_op", i), {27'd0, issue_op}, {27'd0, vecs[i].op});
            chk($sformatf("vec%0d_rob1", i), {28'd0, issue_rob1}, {28'd0, vecs[i].rob1});
            chk($sformatf("vec%0d_rob2", i), {28'd0, issue_rob2}, {28'd0, ~vecs[i].rob1});
            chk($sformatf("vec%0d_dest1", i), {26'd0, issue_phy_dest1}, {26'd0, exp_d1});
            chk($sformatf("vec%0d_dest2", i), {26'd0, issue_phy_dest2}, {26'd0, exp_d2});
            chk($sformatf("vec%0d_we", i), {30'd0, issue_rf_we2, issue_rf_we1},
                {30'd0, vecs[i].rob1[0], 1'b1});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_hi", i), issue_hi, vecs[i].exp_vals[31:0]);
                chk($sformatf("vec%0d_lo", i), issue_lo, vecs[i].exp_vals[63:32]);
                chk($sformatf("vec%0d_src1", i), issue_src1, vecs[i].exp_vals[95:64]);
                chk($sformatf("vec%0d_src2", i), issue_src2, vecs[i].exp_vals[127:96]);
                mul_div_allowin = 1'b1;
            end else begin
                flush = 1'b1;
            end
            tick();
            mul_div_allowin = 1'b0;
            flush           = 1'b0;
            chk($sformatf("vec%0d_drained", i), {31'd0, issue_valid}, 32'd0);
        end

        // DIV waiting on tag 12; woken two cycles after dispatch.
        mul_div_allowin = 1'b1;
        drive_pair(5'd8, 4'd6, 4'b0111, {6'd12, 6'd11, 6'd10, 6'd9},
                   {32'd0, 32'd100, 32'd0, 32'd0});
        dispatch_valid = 1'b1;
        tick();
        dispatch_valid = 1'b0;
        chk("div_wait0", {31'd0, issue_valid}, 32'd0);
        tick();
        chk("div_wait1", {31'd0, issue_valid}, 32'd0);
        wake_we    = 2'b01;
        wake_dest  = {6'd0, 6'd12};
        wake_value = {32'd0, 32'd5};
        chk("div_no_comb_forward", {31'd0, issue_valid}, 32'd0);
        tick();
        clear_wake();
        chk("div_valid", {31'd0, issue_valid}, 32'd1);
        chk("div_src2", issue_src2, 32'd5);
        chk("div_src1", issue_src1, 32'd100);
        tick();
        chk("div_popped", {31'd0, issue_valid}, 32'd0);

        // Fill to full, attempt a fifth push, then drain in order.
        mul_div_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pair(5'd1, 4'(i), 4'b1111, 24'd0, {4{32'(i + 1)}});
            dispatch_valid = 1'b1;
            tick();
            chk($sformatf("fill%0d_allowin", i), {31'd0, dispatch_allowin}, (i == 3) ? 32'd0 : 32'd1);
        end
        drive_pair(5'd1, 4'd7, 4'b1111, 24'd0, {4{32'd7}});
        tick();
        dispatch_valid = 1'b0;
        chk("full_still_blocked", {31'd0, dispatch_allowin}, 32'd0);
        mul_div_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), {31'd0, issue_valid}, 32'd1);
            chk($sformatf("drain%0d_rob1", i), {28'd0, issue_rob1}, 32'(i));
            chk($sformatf("drain%0d_src1", i), issue_src1, 32'(i + 1));
            tick();
        end
        chk("drain_empty", {31'd0, issue_valid}, 32'd0);
        chk("drain_allowin", {31'd0, dispatch_allowin}, 32'd1);

        // Non-ready head blocks a fully ready younger entry.
        drive_pair(5'd1, 4'd0, 4'b1110, {6'd4, 6'd3, 6'd2, 6'd9}, {32'd4, 32'd3, 32'd2, 32'd0});
        dispatch_valid = 1'b1;
        tick();
        drive_pair(5'd1, 4'd1, 4'b1111, 24'd0, {32'd8, 32'd8, 32'd8, 32'd8});
        tick();
        dispatch_valid = 1'b0;
        chk("hol_block0", {31'd0, issue_valid}, 32'd0);
        tick();
        chk("hol_block1", {31'd0, issue_valid}, 32'd0);
        wake_we    = 2'b10;
        wake_dest  = {6'd9, 6'd0};
        wake_value = {32'h909, 32'd0};
        tick();
        clear_wake();
        chk("hol_head_valid", {31'd0, issue_valid}, 32'd1);
        chk("hol_head_rob1", {28'd0, issue_rob1}, 32'd0);
        chk("hol_head_hi", issue_hi, 32'h909);
        tick();
        chk("hol_next_valid", {31'd0, issue_valid}, 32'd1);
        chk("hol_next_rob1", {28'd0, issue_rob1}, 32'd1);
        tick();
        chk("hol_empty", {31'd0, issue_valid}, 32'd0);

        // Flush with three entries resident.
        mul_div_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_pair(5'd4, 4'(i + 1), 4'b1111, 24'd0, {4{32'h77}});
            dispatch_valid = 1'b1;
            tick();
        end
        dispatch_valid = 1'b0;
        chk("pre_flush_allowin", {31'd0, dispatch_allowin}, 32'd1);
        chk("pre_flush_valid", {31'd0, issue_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, issue_valid}, 32'd0);
        chk("flush_allowin", {31'd0, dispatch_allowin}, 32'd1);
        chk("flush_rob1", {28'd0, issue_rob1}, 32'd0);
        chk("flush_src1", issue_src1, 32'd0);
        mul_div_allowin = 1'b1;
        drive_pair(5'd4, 4'd9, 4'b1111, 24'd0, {32'd0, 32'h1234, 32'd0, 32'd0});
        dispatch_valid = 1'b1;
        tick();
        dispatch_valid = 1'b0;
        chk("post_flush_valid", {31'd0, issue_valid}, 32'd1);
        chk("post_flush_rob1", {28'd0, issue_rob1}, 32'd9);
        chk("post_flush_src1", issue_src1, 32'h1234);
        tick();
        chk("post_flush_empty", {31'd0, issue_valid}, 32'd0);

        // Asynchronous reset while full.
        mul_div_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pair(5'd3, 4'(i + 1), 4'b1111, 24'd0, {4{32'h55}});
            dispatch_valid = 1'b1;
            tick();
        end
        dispatch_valid = 1'b0;
        chk("pre_reset_allowin", {31'd0, dispatch_allowin}, 32'd0);
        chk("pre_reset_valid", {31'd0, issue_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_valid", {31'd0, issue_valid}, 32'd0);
        chk("async_reset_allowin", {31'd0, dispatch_allowin}, 32'd1);
        chk("async_reset_op", {27'd0, issue_op}, 32'd0);
        chk("async_reset_rob1", {28'd0, issue_rob1}, 32'd0);
        chk("async_reset_src1", issue_src1, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_valid", {31'd0, issue_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
